// File: rtl/edge_lane.sv
// Single-bit any-edge detector lane.
// Optional synchronizer chain, history flop, first-sample arming gate and
// registered rise/fall/detect strobes. Reset is asynchronous, active-low.
module edge_lane #(
    parameter int SYNC_STAGES = 0
) (
    input  logic d,
    input  logic clk,
    input  logic rst,
    output logic detect,
    output logic rise,
    output logic fall
);

    logic s;
    logic prev_reg;
    logic armed_reg;
    logic detect_reg;
    logic rise_reg;
    logic fall_reg;
    logic rise_next;
    logic fall_next;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = d;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_reg;

            // Shift the raw input through the synchronizer chain
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync_reg <= '0;
                end else begin
                    for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                        sync_reg[i] <= sync_reg[i-1];
                    end
                    sync_reg[0] <= d;
                end
            end

            assign s = sync_reg[SYNC_STAGES-1];
        end
    endgenerate

    // Edge terms between the current sample and the previous one
    always_comb begin
        rise_next = s & ~prev_reg;
        fall_next = ~s & prev_reg;
    end

    // History, arming and registered strobes; the first sample after reset
    // only loads the history so a level already high is not seen as an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_reg   <= 1'b0;
            armed_reg  <= 1'b0;
            detect_reg <= 1'b0;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
        end else begin
            prev_reg  <= s;
            armed_reg <= 1'b1;
            if (armed_reg) begin
                detect_reg <= rise_next | fall_next;
                rise_reg   <= rise_next;
                fall_reg   <= fall_next;
            end else begin
                detect_reg <= 1'b0;
                rise_reg   <= 1'b0;
                fall_reg   <= 1'b0;
            end
        end
    end

    assign detect = detect_reg;
    assign rise   = rise_reg;
    assign fall   = fall_reg;

endmodule

// File: rtl/either_edge_detector.sv
// Multi-bit any-edge detector: WIDTH independent edge_lane instances.
// Produces one-cycle registered detect/rise/fall strobes per bit.
module either_edge_detector #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 0
) (
    input  logic [WIDTH-1:0] D,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] detect,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            edge_lane #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_lane (
                .d      (D[gi]),
                .clk    (clk),
                .rst    (rst),
                .detect (detect[gi]),
                .rise   (rise[gi]),
                .fall   (fall[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_either_edge_detector.sv
// Directed testbench: one 1-bit unsynchronized instance and one 4-bit
// instance with a 2-stage synchronizer, sharing a clock.
module tb_either_edge_detector;

    logic       clk = 1'b0;
    logic       d1;
    logic       rst1;
    logic       det1, rise1, fall1;
    logic [3:0] d4;
    logic       rst4;
    logic [3:0] det4, rise4, fall4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    either_edge_detector #(.WIDTH(1), .SYNC_STAGES(0)) u_dut1 (
        .D      (d1),
        .clk    (clk),
        .rst    (rst1),
        .detect (det1),
        .rise   (rise1),
        .fall   (fall1)
    );

    either_edge_detector #(.WIDTH(4), .SYNC_STAGES(2)) u_dut4 (
        .D      (d4),
        .clk    (clk),
        .rst    (rst4),
        .detect (det4),
        .rise   (rise4),
        .fall   (fall4)
    );

    task automatic check_vec(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", tag, obs, exp);
        end else begin
            $display("vec %0d %s: %b ok", n_vec, tag, obs);
        end
    endtask

    // Check the 1-bit instance's three outputs against {detect, rise, fall}
    task automatic check1(input string tag, input logic [2:0] exp);
        check_vec({tag, " det"},  {3'b0, det1},  {3'b0, exp[2]});
        check_vec({tag, " rise"}, {3'b0, rise1}, {3'b0, exp[1]});
        check_vec({tag, " fall"}, {3'b0, fall1}, {3'b0, exp[0]});
    endtask

    task automatic check4(input string tag, input logic [3:0] ed, input logic [3:0] er, input logic [3:0] ef);
        check_vec({tag, " det"},  det4,  ed);
        check_vec({tag, " rise"}, rise4, er);
        check_vec({tag, " fall"}, fall4, ef);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_r;
        d1 = 1'b0; rst1 = 1'b0;
        d4 = 4'b0; rst4 = 1'b0;

        // Reset held for two cycles
        step; check1("rst c1", 3'b000);
        step; check1("rst c2", 3'b000); check4("rst4", 4'b0, 4'b0, 4'b0);
        @(negedge clk); rst1 = 1'b1; rst4 = 1'b1;
        step; check1("arm cycle", 3'b000);
        step; check1("idle", 3'b000); check4("idle4", 4'b0, 4'b0, 4'b0);

        // Rising edge: change at negedge, pulse for exactly one cycle
        @(negedge clk); d1 = 1'b1;
        step; check1("rise pulse", 3'b110);
        step; check1("rise end", 3'b000);
        step; check1("steady hi", 3'b000);

        // Falling edge
        @(negedge clk); d1 = 1'b0;
        step; check1("fall pulse", 3'b101);
        step; check1("fall end", 3'b000);

        // Toggle every cycle: detect every cycle, rise/fall alternating
        exp_r = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); d1 = ~d1;
            step; check1($sformatf("toggle %0d", i), {1'b1, exp_r, ~exp_r});
            exp_r = ~exp_r;
        end
        step; check1("toggle end", 3'b000);

        // Arming: D high through reset release must not give a false rise
        @(negedge clk); rst1 = 1'b0; d1 = 1'b1;
        #1; check1("rst2 async", 3'b000);
        step; check1("rst2 hold", 3'b000);
        @(negedge clk); rst1 = 1'b1;
        step; check1("arm hi c1", 3'b000);
        step; check1("arm hi c2", 3'b000);
        @(negedge clk); d1 = 1'b0;
        step; check1("arm fall", 3'b101);
        step; check1("arm fall end", 3'b000);

        // 4-bit, 2-stage sync: pulse appears two cycles later than unsynced
        @(negedge clk); d4 = 4'b1010;
        step; check4("sync c1", 4'b0000, 4'b0000, 4'b0000);
        step; check4("sync c2", 4'b0000, 4'b0000, 4'b0000);
        step; check4("sync c3", 4'b1010, 4'b1010, 4'b0000);
        // Reset asserted mid-pulse drops outputs immediately
        #2; rst4 = 1'b0;
        #1; check4("mid rst", 4'b0000, 4'b0000, 4'b0000);
        step; check4("mid rst hold", 4'b0000, 4'b0000, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
